// File: rtl/decoder_3to8_seq_if.sv
// Bus for the registered 3-to-8 decoder: input handshake, one-hot output,
// status and debug state. The block itself connects through the slave modport.
interface decoder_3to8_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] code;
  logic       pulse_mode;
  logic       clr;
  logic [7:0] d;
  logic       d_valid;
  logic       busy;
  logic [7:0] acc_cnt;
  logic [2:0] state;

  modport master (
    output in_valid, code, pulse_mode, clr,
    input  in_ready, d, d_valid, busy, acc_cnt, state
  );

  modport slave (
    input  in_valid, code, pulse_mode, clr,
    output in_ready, d, d_valid, busy, acc_cnt, state
  );
endinterface

// File: rtl/decoder_3to8_seq.sv
// Registered binary-to-one-hot decoder with a hold mode and a fixed-width
// pulse mode, plus a wrapping count of accepted transactions.
module decoder_3to8_seq #(
  parameter int unsigned PULSE_LEN = 4
) (
  input logic                 clk,
  input logic                 rst,
  decoder_3to8_seq_if.slave   bus
);

  // Handshake: a transaction is taken on a rising edge where in_valid and
  // in_ready are both high; code and pulse_mode are sampled on that edge only.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HOLD  = 3'd1,
    PULSE = 3'd2
  } state_t;

  localparam logic [7:0] PULSE_LAST = 8'(PULSE_LEN - 1);

  state_t     state_q, state_d;
  logic [7:0] d_q, d_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] acc_q;
  logic       d_valid_q;
  logic       in_ready;
  logic       accept;

  always_comb begin
    in_ready = !rst && !bus.clr && (state_q == IDLE || state_q == HOLD);
    accept   = bus.in_valid && in_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      d_q       <= 8'h00;
      d_valid_q <= 1'b0;
      cnt_q     <= 8'h00;
      acc_q     <= 8'h00;
    end else begin
      state_q   <= state_d;
      d_q       <= d_d;
      d_valid_q <= (d_d != 8'h00);
      cnt_q     <= cnt_d;
      if (accept) acc_q <= acc_q + 8'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, HOLD: begin
        if (accept) begin
          d_d = 8'd1 << bus.code;
          if (bus.pulse_mode) begin
            state_d = PULSE;
            cnt_d   = PULSE_LAST;
          end else begin
            state_d = HOLD;
          end
        end else if (bus.clr) begin
          state_d = IDLE;
          d_d     = 8'h00;
        end
      end
      PULSE: begin
        // cnt counts the remaining pulse cycles after the current one.
        if (cnt_q != 8'h00) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d = IDLE;
          d_d     = 8'h00;
        end
      end
      default: begin
        state_d = IDLE;
        d_d     = 8'h00;
        cnt_d   = 8'h00;
      end
    endcase
  end

  assign bus.in_ready = in_ready;
  assign bus.d        = d_q;
  assign bus.d_valid  = d_valid_q;
  assign bus.busy     = (state_q == PULSE);
  assign bus.acc_cnt  = acc_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_decoder_3to8_seq.sv
// Directed bench for decoder_3to8_seq: one instance with PULSE_LEN = 4 and
// one with PULSE_LEN = 1, checked against hand-computed values.
module tb_decoder_3to8_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  decoder_3to8_seq_if b0 ();
  decoder_3to8_seq_if b1 ();

  decoder_3to8_seq #(.PULSE_LEN(4)) u0 (.clk(clk), .rst(rst), .bus(b0));
  decoder_3to8_seq #(.PULSE_LEN(1)) u1 (.clk(clk), .rst(rst), .bus(b1));

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HOLD  = 3'd1;
  localparam logic [2:0] ST_PULSE = 3'd2;

  logic [7:0] exp_hold [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [2:0] c, input logic pm, input logic cl);
    b0.in_valid   = v;
    b0.code       = c;
    b0.pulse_mode = pm;
    b0.clr        = cl;
  endtask

  initial begin
    drive0(1'b0, 3'd0, 1'b0, 1'b0);
    b1.in_valid = 1'b0; b1.code = 3'd0; b1.pulse_mode = 1'b0; b1.clr = 1'b0;

    // Reset and idle
    rst = 1'b1;
    step();
    check("ready_in_reset", 32'(b0.in_ready), 32'd0);
    step();
    check("ready_in_reset2", 32'(b0.in_ready), 32'd0);
    check("rst_d", 32'(b0.d), 32'h00);
    check("rst_d_valid", 32'(b0.d_valid), 32'd0);
    check("rst_busy", 32'(b0.busy), 32'd0);
    check("rst_acc", 32'(b0.acc_cnt), 32'd0);
    check("rst_state", 32'(b0.state), 32'(ST_IDLE));
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(b0.in_ready), 32'd1);

    // Hold sweep, back-to-back accepts
    for (int i = 0; i < 8; i++) begin
      drive0(1'b1, 3'(i), 1'b0, 1'b0);
      step();
      check($sformatf("hold_d_%0d", i), 32'(b0.d), 32'(exp_hold[i]));
      check($sformatf("hold_dv_%0d", i), 32'(b0.d_valid), 32'd1);
    end
    drive0(1'b0, 3'd0, 1'b0, 1'b0);
    #1;
    check("hold_acc", 32'(b0.acc_cnt), 32'd8);
    check("hold_state", 32'(b0.state), 32'(ST_HOLD));

    // Pulse from HOLD, in_valid held high throughout
    drive0(1'b1, 3'd5, 1'b1, 1'b0);
    step();
    drive0(1'b1, 3'd1, 1'b0, 1'b0);
    #1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      check($sformatf("pulse_d_%0d", k), 32'(b0.d), 32'h20);
      check($sformatf("pulse_busy_%0d", k), 32'(b0.busy), 32'd1);
      check($sformatf("pulse_ready_%0d", k), 32'(b0.in_ready), 32'd0);
    end
    step();
    drive0(1'b0, 3'd0, 1'b0, 1'b0);
    #1;
    check("pulse_end_d", 32'(b0.d), 32'h00);
    check("pulse_end_dv", 32'(b0.d_valid), 32'd0);
    check("pulse_end_busy", 32'(b0.busy), 32'd0);
    check("pulse_end_ready", 32'(b0.in_ready), 32'd1);
    check("pulse_acc", 32'(b0.acc_cnt), 32'd9);

    // Clear priority over in_valid
    drive0(1'b1, 3'd3, 1'b0, 1'b0);
    step();
    check("clr_pre_d", 32'(b0.d), 32'h08);
    drive0(1'b1, 3'd2, 1'b0, 1'b1);
    #1;
    check("clr_ready", 32'(b0.in_ready), 32'd0);
    step();
    drive0(1'b0, 3'd0, 1'b0, 1'b0);
    #1;
    check("clr_d", 32'(b0.d), 32'h00);
    check("clr_acc", 32'(b0.acc_cnt), 32'd10);
    check("clr_state", 32'(b0.state), 32'(ST_IDLE));

    // Reset mid-pulse
    drive0(1'b1, 3'd7, 1'b1, 1'b0);
    step();
    drive0(1'b0, 3'd0, 1'b0, 1'b0);
    check("rmp_d1", 32'(b0.d), 32'h80);
    step();
    check("rmp_busy2", 32'(b0.busy), 32'd1);
    check("rmp_state2", 32'(b0.state), 32'(ST_PULSE));
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("rmp_d", 32'(b0.d), 32'h00);
    check("rmp_busy", 32'(b0.busy), 32'd0);
    check("rmp_state", 32'(b0.state), 32'(ST_IDLE));
    check("rmp_acc", 32'(b0.acc_cnt), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("rmp_residual_%0d", k), 32'(b0.d), 32'h00);
    end

    // acc_cnt wrap over 256 accepts
    for (int i = 0; i < 256; i++) begin
      drive0(1'b1, 3'(i % 8), 1'b0, 1'b0);
      step();
      if (i == 254) check("wrap_acc_255", 32'(b0.acc_cnt), 32'd255);
    end
    drive0(1'b0, 3'd0, 1'b0, 1'b1);
    #1;
    check("wrap_acc_0", 32'(b0.acc_cnt), 32'd0);
    check("wrap_last_d", 32'(b0.d), 32'h80);
    step();
    drive0(1'b0, 3'd0, 1'b0, 1'b0);
    check("wrap_clr_d", 32'(b0.d), 32'h00);

    // PULSE_LEN = 1 instance
    b1.in_valid = 1'b1; b1.code = 3'd3; b1.pulse_mode = 1'b1;
    step();
    b1.in_valid = 1'b0; b1.pulse_mode = 1'b0;
    #1;
    check("p1_d", 32'(b1.d), 32'h08);
    check("p1_busy", 32'(b1.busy), 32'd1);
    check("p1_ready", 32'(b1.in_ready), 32'd0);
    step();
    check("p1_end_d", 32'(b1.d), 32'h00);
    check("p1_end_busy", 32'(b1.busy), 32'd0);
    check("p1_end_ready", 32'(b1.in_ready), 32'd1);
    check("p1_acc", 32'(b1.acc_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
